// File: rtl/instr_issuer_if.sv
// Loader, run-control and instruction-stream signals between the harness/core and instr_issuer.
interface instr_issuer_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 12
);
    localparam int unsigned CW = 16;

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic [CW-1:0] issued_count;

    modport master (
        output load_en, load_addr, load_data, start, start_addr, end_addr,
               redirect, redirect_addr, instr_ready,
        input  instr_out, instr_valid, pc, busy, done, issued_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, start_addr, end_addr,
               redirect, redirect_addr, instr_ready,
        output instr_out, instr_valid, pc, busy, done, issued_count
    );
endinterface

// File: rtl/instr_issuer.sv
// Program store plus sequential instruction issue over valid/ready, with PC
// ownership and branch redirect from the core.
module instr_issuer #(
    parameter int unsigned AW = 8,
    parameter int unsigned IW = 12
) (
    input  logic           clk,
    input  logic           rst,
    instr_issuer_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] end_q, end_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] instr_q;
    logic          fetch_en;
    logic          mem_we;

    logic [IW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect outranks the handshake: a same-cycle acceptance is dropped.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        end_d    = end_q;
        cnt_d    = cnt_q;
        fetch_en = 1'b0;
        mem_we   = bus.load_en && ((state_q == S_IDLE) || (state_q == S_DONE));
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = bus.start_addr;
                    end_d   = bus.end_addr;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_addr;
                end else begin
                    fetch_en = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_addr;
                    state_d = S_FETCH;
                end else if (bus.instr_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (pc_q == end_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Program memory survives reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
        end else if (fetch_en) begin
            instr_q <= mem[pc_q];
        end
    end

    assign bus.instr_out    = instr_q;
    assign bus.instr_valid  = (state_q == S_ISSUE);
    assign bus.busy         = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.pc           = pc_q;
    assign bus.issued_count = cnt_q;
endmodule

// File: tb/tb_instr_issuer.sv
// Directed per-cycle vector bench for instr_issuer plus hand-written reset/re-run sequence.
module tb_instr_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_issuer_if #(.AW(8), .IW(12)) b ();

    instr_issuer #(.AW(8), .IW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    typedef struct {
        logic        ld;
        logic [7:0]  la;
        logic [11:0] ldat;
        logic        st;
        logic [7:0]  sa;
        logic [7:0]  ea;
        logic        rdy;
        logic        rd;
        logic [7:0]  ra;
        logic        ev;
        logic [11:0] ei;
        logic [7:0]  epc;
        logic        eb;
        logic        ed;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(input int st, input int sa, input int ea, input int rdy,
                                input int ev, input int ei, input int epc, input int eb,
                                input int ed, input int ec);
        vec_t v;
        v.ld = 1'b0; v.la = 8'h00; v.ldat = 12'h000; v.rd = 1'b0; v.ra = 8'h00;
        v.st = 1'(st); v.sa = 8'(sa); v.ea = 8'(ea); v.rdy = 1'(rdy);
        v.ev = 1'(ev); v.ei = 12'(ei); v.epc = 8'(epc); v.eb = 1'(eb);
        v.ed = 1'(ed); v.ec = 16'(ec);
        vecs.push_back(v);
    endfunction

    function automatic void with_load(input int la, input int ldat);
        vecs[vecs.size()-1].ld   = 1'b1;
        vecs[vecs.size()-1].la   = 8'(la);
        vecs[vecs.size()-1].ldat = 12'(ldat);
    endfunction

    function automatic void with_redirect(input int ra);
        vecs[vecs.size()-1].rd = 1'b1;
        vecs[vecs.size()-1].ra = 8'(ra);
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [11:0] d);
        @(negedge clk);
        b.load_en = 1'b1; b.load_addr = a; b.load_data = d;
        @(negedge clk);
        b.load_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b.load_en = 1'b0; b.load_addr = '0; b.load_data = '0;
        b.start = 1'b0; b.start_addr = '0; b.end_addr = '0;
        b.redirect = 1'b0; b.redirect_addr = '0; b.instr_ready = 1'b0;

        // Run A: plain 0..3 with ready held high
        add(1,8'h00,8'h03,1, 0,12'h000,8'h00,0,0,0);
        add(0,0,0,1, 0,12'h000,8'h00,1,0,0);
        add(0,0,0,1, 1,12'h112,8'h00,1,0,0);
        add(0,0,0,1, 0,12'h000,8'h01,1,0,1);
        add(0,0,0,1, 1,12'h234,8'h01,1,0,1);
        add(0,0,0,1, 0,12'h000,8'h02,1,0,2);
        add(0,0,0,1, 1,12'h356,8'h02,1,0,2);
        add(0,0,0,1, 0,12'h000,8'h03,1,0,3);
        add(0,0,0,1, 1,12'h478,8'h03,1,0,3);
        add(0,0,0,1, 0,12'h000,8'h03,0,1,4);
        // Run B: 3-cycle stall on 2nd instr, load and start while busy, start in DONE
        add(1,8'h00,8'h03,1, 0,12'h000,8'h03,0,0,4);
        add(0,0,0,1, 0,12'h000,8'h00,1,0,0);
        add(0,0,0,1, 1,12'h112,8'h00,1,0,0);
        add(0,0,0,0, 0,12'h000,8'h01,1,0,1); with_load(8'h02, 12'hEEE);
        add(0,0,0,0, 1,12'h234,8'h01,1,0,1);
        add(1,8'h05,8'h05,0, 1,12'h234,8'h01,1,0,1);
        add(0,0,0,0, 1,12'h234,8'h01,1,0,1);
        add(0,0,0,1, 1,12'h234,8'h01,1,0,1);
        add(0,0,0,1, 0,12'h000,8'h02,1,0,2);
        add(0,0,0,1, 1,12'h356,8'h02,1,0,2);
        add(0,0,0,1, 0,12'h000,8'h03,1,0,3);
        add(0,0,0,1, 1,12'h478,8'h03,1,0,3);
        add(1,8'h05,8'h05,1, 0,12'h000,8'h03,0,1,4);
        // Run C: redirect to 4 during pc=1 ISSUE with ready high
        add(1,8'h00,8'h05,1, 0,12'h000,8'h03,0,0,4);
        add(0,0,0,1, 0,12'h000,8'h00,1,0,0);
        add(0,0,0,1, 1,12'h112,8'h00,1,0,0);
        add(0,0,0,1, 0,12'h000,8'h01,1,0,1);
        add(0,0,0,1, 1,12'h234,8'h01,1,0,1); with_redirect(8'h04);
        add(0,0,0,1, 0,12'h000,8'h04,1,0,1);
        add(0,0,0,1, 1,12'h5AA,8'h04,1,0,1);
        add(0,0,0,1, 0,12'h000,8'h05,1,0,2);
        add(0,0,0,1, 1,12'h6BB,8'h05,1,0,2);
        add(0,0,0,1, 0,12'h000,8'h05,0,1,3);
        add(0,0,0,1, 0,12'h000,8'h05,0,0,3); with_redirect(8'h09);
        // Run D: single-instruction run at FF (also shows IDLE redirect ignored)
        add(1,8'hFF,8'hFF,1, 0,12'h000,8'h05,0,0,3);
        add(0,0,0,1, 0,12'h000,8'hFF,1,0,0);
        add(0,0,0,1, 1,12'hBFF,8'hFF,1,0,0);
        add(0,0,0,1, 0,12'h000,8'hFF,0,1,1);
        // Run E: wrap FE -> 01
        add(1,8'hFE,8'h01,1, 0,12'h000,8'hFF,0,0,1);
        add(0,0,0,1, 0,12'h000,8'hFE,1,0,0);
        add(0,0,0,1, 1,12'hAFE,8'hFE,1,0,0);
        add(0,0,0,1, 0,12'h000,8'hFF,1,0,1);
        add(0,0,0,1, 1,12'hBFF,8'hFF,1,0,1);
        add(0,0,0,1, 0,12'h000,8'h00,1,0,2);
        add(0,0,0,1, 1,12'h112,8'h00,1,0,2);
        add(0,0,0,1, 0,12'h000,8'h01,1,0,3);
        add(0,0,0,1, 1,12'h234,8'h01,1,0,3);
        add(0,0,0,1, 0,12'h000,8'h01,0,1,4);
        // Run F: load and start in the same IDLE cycle
        add(1,8'h00,8'h00,1, 0,12'h000,8'h01,0,0,4); with_load(8'h00, 12'h9C1);
        add(0,0,0,1, 0,12'h000,8'h00,1,0,0);
        add(0,0,0,1, 1,12'h9C1,8'h00,1,0,0);
        add(0,0,0,1, 0,12'h000,8'h00,0,1,1);
        add(0,0,0,0, 0,12'h000,8'h00,0,0,1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 16'(b.instr_valid), 16'h0);
        chk("rst_instr", 16'(b.instr_out), 16'h0);
        chk("rst_pc", 16'(b.pc), 16'h0);
        chk("rst_busy", 16'(b.busy), 16'h0);
        chk("rst_done", 16'(b.done), 16'h0);
        chk("rst_count", 16'(b.issued_count), 16'h0);

        do_load(8'h00, 12'h112); do_load(8'h01, 12'h234);
        do_load(8'h02, 12'h356); do_load(8'h03, 12'h478);
        do_load(8'h04, 12'h5AA); do_load(8'h05, 12'h6BB);
        do_load(8'hFE, 12'hAFE); do_load(8'hFF, 12'hBFF);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic ok;
            v = vecs[i];
            @(negedge clk);
            ok = (b.instr_valid === v.ev) && (!v.ev || (b.instr_out === v.ei)) &&
                 (b.pc === v.epc) && (b.busy === v.eb) && (b.done === v.ed) &&
                 (b.issued_count === v.ec);
            n_total++;
            if (ok) n_pass++;
            else $display("FAIL vec%0d: got v=%b i=%h pc=%h b=%b d=%b n=%0d want v=%b i=%h pc=%h b=%b d=%b n=%0d",
                          i, b.instr_valid, b.instr_out, b.pc, b.busy, b.done, b.issued_count,
                          v.ev, v.ei, v.epc, v.eb, v.ed, v.ec);
            b.load_en = v.ld; b.load_addr = v.la; b.load_data = v.ldat;
            b.start = v.st; b.start_addr = v.sa; b.end_addr = v.ea;
            b.instr_ready = v.rdy; b.redirect = v.rd; b.redirect_addr = v.ra;
        end

        // Reset during ISSUE aborts without a done pulse
        @(negedge clk);
        b.start = 1'b1; b.start_addr = 8'h00; b.end_addr = 8'h03; b.instr_ready = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 16'(b.instr_valid), 16'h1);
        chk("pre_rst_instr", 16'(b.instr_out), 16'h9C1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", 16'(b.instr_valid), 16'h0);
        chk("abort_busy", 16'(b.busy), 16'h0);
        chk("abort_pc", 16'(b.pc), 16'h0);
        chk("abort_done", 16'(b.done), 16'h0);
        chk("abort_count", 16'(b.issued_count), 16'h0);
        chk("abort_instr", 16'(b.instr_out), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_done", 16'(b.done), 16'h0);
        chk("post_abort_busy", 16'(b.busy), 16'h0);

        // Re-run from retained memory contents
        b.start = 1'b1; b.start_addr = 8'h00; b.end_addr = 8'h03;
        @(negedge clk);
        b.start = 1'b0;
        for (int i = 0; i < 10 && !b.instr_valid; i++) @(negedge clk);
        chk("rerun_valid", 16'(b.instr_valid), 16'h1);
        chk("rerun_instr0", 16'(b.instr_out), 16'h9C1);
        for (int i = 0; i < 30 && !b.done; i++) @(negedge clk);
        chk("rerun_done", 16'(b.done), 16'h1);
        chk("rerun_count", 16'(b.issued_count), 16'd4);
        chk("rerun_pc", 16'(b.pc), 16'h3);
        @(negedge clk);
        chk("rerun_done_pulse", 16'(b.done), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
